// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle input and imem write port of the instruction encoder
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_type;
   logic [6:0]        in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_func3;
   logic [6:0]        in_func7;
   logic [31:0]       in_imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   // Field source / memory observer side
   modport master (
      output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
             in_func3, in_func7, in_imm,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   // Encoder side
   modport slave (
      input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
             in_func3, in_func7, in_imm,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs RV32I fields into instruction words and writes them to imem
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clr,
   instr_encoder_if.slave    bus,
   output logic [ADDR_W:0]   count,
   output logic [1:0]        state,
   output logic [2:0]        err_code
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FULL = 2'd2,
      ST_ERR  = 2'd3
   } st_t;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   st_t              st;
   logic [31:0]      word;
   logic [2:0]       code;
   logic             accept;
   logic [ADDR_W:0]  count_nxt;

   assign state        = st;
   assign bus.in_ready = (st == ST_RUN) && (count < DEPTH_C);
   // clr wins over a bundle presented in the same cycle
   assign accept       = bus.in_valid && bus.in_ready && !clr;
   assign count_nxt    = count + (ADDR_W+1)'(1);

   // Format the incoming fields and flag the first failing legality check
   always_comb begin
      word = 32'h0;
      code = 3'd0;
      case (bus.in_type)
         3'd0: word = {bus.in_func7, bus.in_rs2, bus.in_rs1, bus.in_func3,
                       bus.in_rd, bus.in_opcode};
         3'd1: begin
            word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, bus.in_opcode};
            if (bus.in_imm[31:11] != {21{bus.in_imm[11]}}) code = 3'd2;
         end
         3'd2: begin
            word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                    bus.in_imm[4:0], bus.in_opcode};
            if (bus.in_imm[31:11] != {21{bus.in_imm[11]}}) code = 3'd2;
         end
         3'd3: begin
            word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                    bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
            if (bus.in_imm[31:12] != {20{bus.in_imm[12]}}) code = 3'd2;
            else if (bus.in_imm[0])                         code = 3'd3;
         end
         3'd4: begin
            word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
            if (bus.in_imm[11:0] != 12'h0) code = 3'd4;
         end
         3'd5: begin
            word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                    bus.in_rd, bus.in_opcode};
            if (bus.in_imm[31:20] != {12{bus.in_imm[20]}}) code = 3'd2;
            else if (bus.in_imm[0])                         code = 3'd3;
         end
         default: code = 3'd1;
      endcase
   end

   // Session FSM, write stage and word counter; a staged write still issues during clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= ST_IDLE;
         count         <= '0;
         err_code      <= 3'd0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= BASE_C;
         bus.mem_wdata <= 32'h0;
      end else begin
         bus.mem_we <= 1'b0;
         if (clr) begin
            st       <= ST_IDLE;
            count    <= '0;
            err_code <= 3'd0;
         end else begin
            case (st)
               ST_IDLE: if (start) st <= ST_RUN;
               ST_RUN: begin
                  if (accept) begin
                     if (code != 3'd0) begin
                        st       <= ST_ERR;
                        err_code <= code;
                     end else begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= BASE_C + count[ADDR_W-1:0];
                        bus.mem_wdata <= word;
                        count         <= count_nxt;
                        if (count_nxt == DEPTH_C) st <= ST_FULL;
                     end
                  end
               end
               default: st <= st;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - model-based directed bench for instr_encoder
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, clr;
   logic        in_valid;
   logic [2:0]  in_type;
   logic [6:0]  in_opcode, in_func7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_func3;
   logic [31:0] in_imm;

   logic [8:0]  cnt_a, cnt_b;
   logic [1:0]  st_a, st_b;
   logic [2:0]  err_a, err_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(8)) ifa ();
   instr_encoder_if #(.ADDR_W(8)) ifb ();

   assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
   assign ifa.in_type  = in_type;   assign ifb.in_type  = in_type;
   assign ifa.in_opcode = in_opcode; assign ifb.in_opcode = in_opcode;
   assign ifa.in_rd    = in_rd;     assign ifb.in_rd    = in_rd;
   assign ifa.in_rs1   = in_rs1;    assign ifb.in_rs1   = in_rs1;
   assign ifa.in_rs2   = in_rs2;    assign ifb.in_rs2   = in_rs2;
   assign ifa.in_func3 = in_func3;  assign ifb.in_func3 = in_func3;
   assign ifa.in_func7 = in_func7;  assign ifb.in_func7 = in_func7;
   assign ifa.in_imm   = in_imm;    assign ifb.in_imm   = in_imm;

   instr_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .bus(ifa.slave),
      .count(cnt_a), .state(st_a), .err_code(err_a));

   instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .bus(ifb.slave),
      .count(cnt_b), .state(st_b), .err_code(err_b));

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] fld(logic [31:0] v, int hi, int lo);
      logic [31:0] m;
      m = (32'h1 << (hi - lo + 1)) - 32'h1;
      return (v >> lo) & m;
   endfunction

   function automatic logic [31:0] model_word(int t, int op, int rd, int rs1, int rs2,
                                              int f3, int f7, logic [31:0] imm);
      logic [31:0] base;
      base = 32'(op) | (32'(f3) << 12);
      case (t)
         0: return base | (32'(rd) << 7) | (32'(rs1) << 15) | (32'(rs2) << 20) | (32'(f7) << 25);
         1: return base | (32'(rd) << 7) | (32'(rs1) << 15) | (fld(imm, 11, 0) << 20);
         2: return base | (fld(imm, 4, 0) << 7) | (32'(rs1) << 15) | (32'(rs2) << 20)
                        | (fld(imm, 11, 5) << 25);
         3: return base | (fld(imm, 11, 11) << 7) | (fld(imm, 4, 1) << 8) | (32'(rs1) << 15)
                        | (32'(rs2) << 20) | (fld(imm, 10, 5) << 25) | (fld(imm, 12, 12) << 31);
         4: return 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFFF000);
         5: return 32'(op) | (32'(rd) << 7) | (fld(imm, 19, 12) << 12) | (fld(imm, 11, 11) << 20)
                           | (fld(imm, 10, 1) << 21) | (fld(imm, 20, 20) << 31);
         default: return 32'h0;
      endcase
   endfunction

   function automatic int model_code(int t, logic [31:0] imm);
      int s;
      s = $signed(imm);
      if (t > 5) return 1;
      if ((t == 1 || t == 2) && (s < -2048 || s > 2047)) return 2;
      if (t == 3 && (s < -4096 || s > 4095)) return 2;
      if (t == 5 && (s < -1048576 || s > 1048575)) return 2;
      if ((t == 3 || t == 5) && (s % 2 != 0)) return 3;
      if (t == 4 && (s & 'hFFF) != 0) return 4;
      return 0;
   endfunction

   function automatic int dep(int i);
      return (i == 0) ? 256 : 4;
   endfunction

   int          m_state [2];
   int          m_count [2];
   int          m_err   [2];
   int          m_we    [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];

   // Model: 0 idle, 1 run, 2 full, 3 err
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_state[i] = 0; m_count[i] = 0; m_err[i] = 0; m_we[i] = 0;
            m_addr[i] = 0; m_wdata[i] = 0;
         end else begin
            m_we[i] = 0;
            if (clr) begin
               m_state[i] = 0; m_count[i] = 0; m_err[i] = 0;
            end else if (m_state[i] == 0 && start) begin
               m_state[i] = 1;
            end else if (m_state[i] == 1 && in_valid && m_count[i] < dep(i)) begin
               if (model_code(in_type, in_imm) != 0) begin
                  m_state[i] = 3;
                  m_err[i]   = model_code(in_type, in_imm);
               end else begin
                  m_we[i]    = 1;
                  m_addr[i]  = m_count[i] % 256;
                  m_wdata[i] = model_word(in_type, in_opcode, in_rd, in_rs1, in_rs2,
                                          in_func3, in_func7, in_imm);
                  m_count[i] = m_count[i] + 1;
                  if (m_count[i] == dep(i)) m_state[i] = 2;
               end
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   logic [31:0] d_we [2], d_addr [2], d_wdata [2], d_cnt [2], d_st [2], d_err [2], d_rdy [2];
   assign d_we[0] = 32'(ifa.mem_we);     assign d_we[1] = 32'(ifb.mem_we);
   assign d_addr[0] = 32'(ifa.mem_addr); assign d_addr[1] = 32'(ifb.mem_addr);
   assign d_wdata[0] = ifa.mem_wdata;    assign d_wdata[1] = ifb.mem_wdata;
   assign d_cnt[0] = 32'(cnt_a);         assign d_cnt[1] = 32'(cnt_b);
   assign d_st[0] = 32'(st_a);           assign d_st[1] = 32'(st_b);
   assign d_err[0] = 32'(err_a);         assign d_err[1] = 32'(err_b);
   assign d_rdy[0] = 32'(ifa.in_ready);  assign d_rdy[1] = 32'(ifb.in_ready);

   logic [39:0] wq [$];
   int          wb_cnt = 0;

   // Compare every DUT output against the model on each falling edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d_we", i),    d_we[i],    32'(m_we[i]));
         chk($sformatf("u%0d_addr", i),  d_addr[i],  m_addr[i]);
         chk($sformatf("u%0d_wdata", i), d_wdata[i], m_wdata[i]);
         chk($sformatf("u%0d_count", i), d_cnt[i],   32'(m_count[i]));
         chk($sformatf("u%0d_state", i), d_st[i],    32'(m_state[i]));
         chk($sformatf("u%0d_err", i),   d_err[i],   32'(m_err[i]));
         chk($sformatf("u%0d_ready", i), d_rdy[i],
             32'(m_state[i] == 1 && m_count[i] < dep(i)));
      end
      if (ifa.mem_we) wq.push_back({ifa.mem_addr, ifa.mem_wdata});
      if (ifb.mem_we) wb_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(int t, int op, int rd, int rs1, int rs2, int f3, int f7,
                        logic [31:0] imm);
      in_valid = 1'b1; in_type = 3'(t); in_opcode = 7'(op); in_rd = 5'(rd);
      in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_func3 = 3'(f3); in_func7 = 7'(f7);
      in_imm = imm;
   endtask

   task automatic restart();
      clr = 1'b1;   tick(); clr = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic expect_err(string name, int t, int op, logic [31:0] imm, int code);
      restart();
      drive(t, op, 1, 1, 2, 0, 0, imm);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_state"}, 32'(st_a), 32'd3);
      chk({name, "_code"},  32'(err_a), 32'(code));
      chk({name, "_ready"}, 32'(ifa.in_ready), 32'd0);
      chk({name, "_we"},    32'(ifa.mem_we), 32'd0);
   endtask

   logic [31:0] t2_exp [5];

   initial begin
      t2_exp[0] = 32'h00500093; t2_exp[1] = 32'h0020A423; t2_exp[2] = 32'hFE208EE3;
      t2_exp[3] = 32'h123452B7; t2_exp[4] = 32'h001000EF;
      rst_n = 1'b0; start = 1'b0; clr = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0); in_valid = 1'b0;

      // Pin the model against hand-computed words
      chk("model_r_add", model_word(0, 'h33, 3, 1, 2, 0, 0, 32'h0), 32'h002081B3);
      chk("model_b_beq", model_word(3, 'h63, 0, 1, 2, 0, 0, -32'sd4), 32'hFE208EE3);
      chk("model_j_jal", model_word(5, 'h6F, 1, 0, 0, 0, 0, 32'd2048), 32'h001000EF);
      chk("model_code_b3", 32'(model_code(3, 32'd3)), 32'd3);

      tick(); tick();
      @(negedge clk);
      chk("reset_state", 32'(st_a), 32'd0);
      chk("reset_wdata", ifa.mem_wdata, 32'h0);
      tick();
      rst_n = 1'b1;

      // T1
      start = 1'b1; tick(); start = 1'b0;
      drive(0, 'h33, 3, 1, 2, 0, 0, 32'h0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_we", 32'(ifa.mem_we), 32'd1);
      chk("t1_addr", 32'(ifa.mem_addr), 32'd0);
      chk("t1_wdata", ifa.mem_wdata, 32'h002081B3);
      chk("t1_count", 32'(cnt_a), 32'd1);

      // T2 on the deep instance; T3 on the DEPTH=4 instance with the same five bundles
      restart();
      wq.delete(); wb_cnt = 0;
      drive(1, 'h13, 1, 0, 0, 0, 0, 32'd5);          tick();
      drive(2, 'h23, 0, 1, 2, 2, 0, 32'd8);          tick();
      drive(3, 'h63, 0, 1, 2, 0, 0, -32'sd4);        tick();
      drive(4, 'h37, 5, 0, 0, 0, 0, 32'h12345000);   tick();
      drive(5, 'h6F, 1, 0, 0, 0, 0, 32'd2048);       tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("t2_nwrites", 32'(wq.size()), 32'd5);
      for (int k = 0; k < 5 && k < wq.size(); k++) begin
         chk($sformatf("t2_addr%0d", k), 32'(wq[k][39:32]), 32'(k));
         chk($sformatf("t2_word%0d", k), wq[k][31:0], t2_exp[k]);
      end
      chk("t3_state", 32'(st_b), 32'd2);
      chk("t3_count", 32'(cnt_b), 32'd4);
      chk("t3_ready", 32'(ifb.in_ready), 32'd0);
      chk("t3_writes", 32'(wb_cnt), 32'd4);

      // T4
      expect_err("t4", 3, 'h63, 32'd3, 3);
      clr = 1'b1; tick(); clr = 1'b0;
      @(negedge clk);
      chk("t4_clr_state", 32'(st_a), 32'd0);
      chk("t4_clr_code", 32'(err_a), 32'd0);
      chk("t4_clr_count", 32'(cnt_a), 32'd0);

      // T5
      expect_err("t5_i_range", 1, 'h13, 32'd2048, 2);
      expect_err("t5_type7", 7, 'h13, 32'd0, 1);
      expect_err("t5_u_low", 4, 'h37, 32'h1, 4);

      // T6: reset lands while a write is staged
      restart();
      drive(1, 'h13, 1, 0, 0, 0, 0, 32'd5);
      tick();
      #1 rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_rst_we", 32'(ifa.mem_we), 32'd0);
      chk("t6_rst_count", 32'(cnt_a), 32'd0);
      chk("t6_rst_wdata", ifa.mem_wdata, 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      drive(1, 'h13, 1, 0, 0, 0, 0, 32'd5);
      clr = 1'b1;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("t6_clr_count", 32'(cnt_a), 32'd0);
      chk("t6_clr_state", 32'(st_a), 32'd0);
      chk("t6_clr_we", 32'(ifa.mem_we), 32'd0);
      tick(); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
